// File: rtl/fifo_dp_flags_pkg.sv
// Shared defaults for the dual-port FIFO family: data/address widths and
// the almost-full / almost-empty margins.
package fifo_dp_flags_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_ADDR_WIDTH = 10;
  localparam int FIFO_AF_MARGIN  = 4;
  localparam int FIFO_AE_MARGIN  = 4;

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: one write port, one synchronously read port.
// Kept behavioural so it can be swapped for a RAM macro.
module fifo_dp_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [1<<ADDR_WIDTH];

  // A read and write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/fifo_dp_flags.sv
// Synchronous dual-port FIFO with occupancy count, threshold flags,
// dout_valid and one-cycle overflow/underflow pulses.
module fifo_dp_flags
  import fifo_dp_flags_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_MARGIN  = FIFO_AF_MARGIN,
  parameter int AE_MARGIN  = FIFO_AE_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  we_n,
  input  logic                  oe_n,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_MARGIN);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  dout_valid_q, overflow_q, underflow_q;
  logic                  dout_live_q;
  logic                  rd_ok, wr_ok;
  logic [WIDTH-1:0]      ram_rdata;

  // Handshake: we_n/oe_n are requests, sampled every edge. A read is accepted
  // only when not empty; a write when not full or when a read is accepted in
  // the same cycle. Rejected requests produce a one-cycle overflow/underflow
  // pulse; an accepted read produces dout_valid one cycle later.
  assign rd_ok = !oe_n && !empty;
  assign wr_ok = !we_n && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      dout_live_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= rd_ok;
      overflow_q   <= !we_n && !wr_ok;
      underflow_q  <= !oe_n && !rd_ok;
      if (rd_ok) dout_live_q <= 1'b1;
    end
  end

  fifo_dp_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && rst_n),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_ok && rst_n),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; dout reads as zero until the first
  // pop after reset, then holds the last popped word.
  assign dout         = dout_live_q ? ram_rdata : '0;
  assign dout_valid   = dout_valid_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_dp_flags.sv
// Bench for fifo_dp_flags: a short hand-computed vector table, then directed
// fill/drain/simultaneous/wrap/reset sequences against a queue-based model.
module tb_fifo_dp_flags;

  localparam int WIDTH = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int AFM   = 4;
  localparam int AEM   = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic             we_n  = 1'b1;
  logic             oe_n  = 1'b1;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AW:0]      count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_dp_flags #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (AW),
    .AF_MARGIN  (AFM),
    .AE_MARGIN  (AEM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .we_n         (we_n),
    .oe_n         (oe_n),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // scoreboard / reference model
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout  = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf   = 1'b0;
  logic             m_unf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic we, input logic oe,
                            input logic [WIDTH-1:0] d);
    logic rd, wr;
    if (rst) begin
      exp_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      return;
    end
    rd = oe && (exp_q.size() > 0);
    wr = we && ((exp_q.size() < DEPTH) || rd);
    if (rd) m_dout = exp_q.pop_front();
    m_valid = rd;
    if (wr) exp_q.push_back(d);
    m_ovf = we && !wr;
    m_unf = oe && !rd;
  endtask

  task automatic check_model();
    int n;
    n = exp_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - AFM));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AEM));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // driver: called just after a negedge; drives one cycle and checks at the next negedge
  task automatic drive(input logic rst, input logic we, input logic oe,
                       input logic [WIDTH-1:0] d);
    rst_n = !rst;
    we_n  = !we;
    oe_n  = !oe;
    din   = d;
    @(posedge clk);
    model_step(rst, we, oe, d);
    @(negedge clk);
  endtask

  task automatic cycle(input logic rst, input logic we, input logic oe,
                       input logic [WIDTH-1:0] d);
    drive(rst, we, oe, d);
    check_model();
  endtask

  // vector table: hand-computed expectations for a short sequence from empty
  typedef struct {
    logic             rst, we, oe;
    logic [WIDTH-1:0] d;
    int               cnt;
    logic             emp, ae, vld, ovf, unf;
    logic [WIDTH-1:0] dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic we, oe;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h3C, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77};

    @(negedge clk);

    // reset held for two cycles
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].oe, tbl[i].d);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(0));
      chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("v%0d_valid", i), 32'(dout_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
    end
    cycle(1'b0, 1'b0, 1'b1, '0);  // drain the leftover word

    // fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'(1));
    cycle(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("fill_overflow", 32'(overflow), 32'(1));
    chk("fill_count", 32'(count), 32'(DEPTH));

    // drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("drain_last", 32'(dout), 32'(8'((DEPTH - 1) & 8'hFF)));
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("drain_underflow", 32'(underflow), 32'(1));

    // simultaneous read+write at count=5
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    chk("simul_count5", 32'(count), 32'(5));

    // simultaneous at full
    while (exp_q.size() < DEPTH) cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    chk("simul_full_no_ovf", 32'(overflow), 32'(0));

    // simultaneous at empty
    while (exp_q.size() > 0) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    chk("simul_empty_count", 32'(count), 32'(1));
    chk("simul_empty_unf", 32'(underflow), 32'(1));

    // random traffic with occupancy held in 1..8
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 3) != 0);
      oe = ($urandom_range(0, 3) != 0);
      if (exp_q.size() <= 1) oe = 1'b0;
      if (exp_q.size() >= 8) we = 1'b0;
      cycle(1'b0, we, oe, 8'($urandom_range(0, 255)));
    end

    // reset in the middle of operation
    while (exp_q.size() < 10) cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("midrst_empty", 32'(empty), 32'(1));
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("midrst_unf", 32'(underflow), 32'(1));
    chk("midrst_valid", 32'(dout_valid), 32'(0));
    cycle(1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
